fetch_sequencer: RTL and testbench

Program-counter sequencer and IF/ID pipeline register for the word-addressed MIPS-subset datapath. Drives the address of the combinational instruction memory, latches the returned word with its PC+1 into the IF/ID register, and applies stall, taken-branch redirect/squash and halt detection. Sits between the instruction memory and the decode stage; the decode stage resolves branches and returns `branch_taken`/`branch_offset`.

---
 rtl/fetch_sequencer_if.sv | 25 ++
 rtl/fetch_sequencer.sv | 117 +++++++++++
 tb/tb_fetch_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus between the PC sequencer, the instruction memory and decode.
// The slave view is the sequencer; the master view is memory/decode/control.
interface fetch_sequencer_if;
  logic        start;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic [31:0] IF_ID_Instruction;
  logic [31:0] IF_ID_PC_plus1;
  logic        IF_ID_valid;
  logic        halted;
  logic [15:0] fetch_count;

  modport slave (
    input  start, stall, branch_taken, branch_offset, Instruction,
    output PC, IF_ID_Instruction, IF_ID_PC_plus1, IF_ID_valid, halted, fetch_count
  );

  modport master (
    output start, stall, branch_taken, branch_offset, Instruction,
    input  PC, IF_ID_Instruction, IF_ID_PC_plus1, IF_ID_valid, halted, fetch_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// PC sequencer and IF/ID pipeline register with stall, taken-branch
// redirect/squash and halt detection on program-space limit or halt word.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter logic [31:0] PC_LIMIT   = 32'd6,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic               clk,
  input  logic               rst,
  fetch_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc1_q, ifid_pc1_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        halted_q, halted_d;
  logic [15:0] count_q, count_d;

  logic [31:0] pc_plus1_s;
  logic [31:0] br_target_s;
  logic        halt_hit_s;

  assign pc_plus1_s  = pc_q + 32'd1;
  // Branch offset is relative to the PC+1 of the instruction in decode.
  assign br_target_s = ifid_pc1_q + {{16{bus.branch_offset[15]}}, bus.branch_offset};
  assign halt_hit_s  = (pc_q >= PC_LIMIT) || (bus.Instruction == HALT_INSTR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      ifid_instr_q <= 32'd0;
      ifid_pc1_q   <= 32'd0;
      ifid_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      count_q      <= 16'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc1_q   <= ifid_pc1_d;
      ifid_valid_q <= ifid_valid_d;
      halted_q     <= halted_d;
      count_q      <= count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc1_d   = ifid_pc1_q;
    ifid_valid_d = ifid_valid_q;
    halted_d     = halted_q;
    count_d      = count_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_FETCH: begin
        if (bus.branch_taken) begin
          pc_d         = br_target_s;
          ifid_valid_d = 1'b0;
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else if (halt_hit_s) begin
          ifid_valid_d = 1'b0;
          halted_d     = 1'b1;
          state_d      = ST_HALT;
        end else begin
          ifid_instr_d = bus.Instruction;
          ifid_pc1_d   = pc_plus1_s;
          ifid_valid_d = 1'b1;
          pc_d         = pc_plus1_s;
          count_d      = (count_q == 16'hFFFF) ? count_q : (count_q + 16'd1);
        end
      end

      ST_HALT: begin
        ifid_valid_d = 1'b0;
        if (bus.start) begin
          state_d  = ST_IDLE;
          pc_d     = RESET_PC;
          halted_d = 1'b0;
        end else begin
          state_d = ST_HALT;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.PC                = pc_q;
  assign bus.IF_ID_Instruction = ifid_instr_q;
  assign bus.IF_ID_PC_plus1    = ifid_pc1_q;
  assign bus.IF_ID_valid       = ifid_valid_q;
  assign bus.halted            = halted_q;
  assign bus.fetch_count       = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed, table-driven bench for fetch_sequencer with a small behavioural ROM.
module tb_fetch_sequencer;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  fetch_sequencer_if bus ();
  logic [31:0] rom [0:7];

  localparam logic [31:0] W0 = 32'h1111_0000;
  localparam logic [31:0] W1 = 32'h2222_0001;
  localparam logic [31:0] W2 = 32'h3333_0002;
  localparam logic [31:0] WH = 32'hFFFF_FFFF;
  localparam logic [31:0] W3 = 32'h4444_0003;
  localparam logic [31:0] W4 = 32'h5555_0004;
  localparam logic [31:0] W5 = 32'h6666_0005;

  assign bus.Instruction = (bus.PC < 32'd8) ? rom[bus.PC[2:0]] : 32'h0000_0000;

  fetch_sequencer #(
    .RESET_PC  (32'd0),
    .PC_LIMIT  (32'd6),
    .HALT_INSTR(32'hFFFF_FFFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        stall;
    logic        br;
    logic [15:0] off;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc1;
    logic        valid;
    logic        halted;
    logic [15:0] count;
  } vec_t;

  vec_t vecs [0:18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                         input logic [31:0] pc1, input logic valid, input logic halted,
                         input logic [15:0] count);
    chk({tag, " PC"},     bus.PC, pc);
    chk({tag, " instr"},  bus.IF_ID_Instruction, instr);
    chk({tag, " pc1"},    bus.IF_ID_PC_plus1, pc1);
    chk({tag, " valid"},  {31'd0, bus.IF_ID_valid}, {31'd0, valid});
    chk({tag, " halted"}, {31'd0, bus.halted}, {31'd0, halted});
    chk({tag, " count"},  {16'd0, bus.fetch_count}, {16'd0, count});
  endtask

  task automatic drive(input logic s, input logic st, input logic b, input logic [15:0] o);
    bus.start         = s;
    bus.stall         = st;
    bus.branch_taken  = b;
    bus.branch_offset = o;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_halt(input string tag);
    int cyc;
    cyc = 0;
    while (!bus.halted && cyc < 40) begin
      tick();
      cyc++;
    end
    chk({tag, " halt reached"}, {31'd0, bus.halted}, 32'd1);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rom[0] = W0; rom[1] = W1; rom[2] = W2; rom[3] = WH;
    rom[4] = W4; rom[5] = W5; rom[6] = 32'h7777_0006; rom[7] = 32'h8888_0007;

    //          start stall br  off       PC     instr pc1    v     h     count
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 32'd1, W0,    32'd1, 1'b1, 1'b0, 16'd1};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 32'd2, W1,    32'd2, 1'b1, 1'b0, 16'd2};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 32'd2, W1,    32'd2, 1'b1, 1'b0, 16'd2};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 32'd2, W1,    32'd2, 1'b1, 1'b0, 16'd2};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 32'd2, W1,    32'd2, 1'b1, 1'b0, 16'd2};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 32'd3, W2,    32'd3, 1'b1, 1'b0, 16'd3};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 16'h0001, 32'd4, W2,    32'd3, 1'b0, 1'b0, 16'd3};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 32'd5, W4,    32'd5, 1'b1, 1'b0, 16'd4};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 16'hFFFD, 32'd2, W4,    32'd5, 1'b0, 1'b0, 16'd4};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 32'd3, W2,    32'd3, 1'b1, 1'b0, 16'd5};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 16'hFFFD, 32'd0, W2,    32'd3, 1'b0, 1'b0, 16'd5};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 16'h0000, 32'd1, W0,    32'd1, 1'b1, 1'b0, 16'd6};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 16'h0000, 32'd2, W1,    32'd2, 1'b1, 1'b0, 16'd7};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 16'h0000, 32'd3, W2,    32'd3, 1'b1, 1'b0, 16'd8};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 16'h0000, 32'd3, W2,    32'd3, 1'b0, 1'b1, 16'd8};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 16'h0000, 32'd3, W2,    32'd3, 1'b0, 1'b1, 16'd8};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 16'h0000, 32'd0, W2,    32'd3, 1'b0, 1'b0, 16'd8};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 16'h0005, 32'd0, W2,    32'd3, 1'b0, 1'b0, 16'd8};

    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_all("reset", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 16'd0);

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].start, vecs[i].stall, vecs[i].br, vecs[i].off);
      tick();
      chk_all($sformatf("row%0d", i), vecs[i].pc, vecs[i].instr, vecs[i].pc1,
              vecs[i].valid, vecs[i].halted, vecs[i].count);
    end

    // Async reset between edges while fetching.
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    tick();
    chk("pre-rst valid", {31'd0, bus.IF_ID_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async rst", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 16'd0);
    #1;
    rst = 1'b0;

    // Fresh run from reset into the halt word at address 3.
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    chk_all("run f0", 32'd1, W0, 32'd1, 1'b1, 1'b0, 16'd1);
    tick();
    chk_all("run f1", 32'd2, W1, 32'd2, 1'b1, 1'b0, 16'd2);
    tick();
    chk_all("run f2", 32'd3, W2, 32'd3, 1'b1, 1'b0, 16'd3);
    tick();
    chk_all("run halt", 32'd3, W2, 32'd3, 1'b0, 1'b1, 16'd3);

    // PC-limit halt with no halt word in the program.
    rom[3] = W3;
    rst = 1'b1;
    #3;
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    wait_halt("limit");
    chk_all("limit", 32'd6, W5, 32'd6, 1'b0, 1'b1, 16'd6);
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    chk_all("restart", 32'd0, W5, 32'd6, 1'b0, 1'b0, 16'd6);
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    chk_all("refetch", 32'd1, W0, 32'd1, 1'b1, 1'b0, 16'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
